delay_slot_arbiter: RTL and testbench
=====================================

# delay_slot_arbiter

Shares one 6-bit tick counter among four requesters that each need a timed interval in the driving simulator (indicator blink, debounce hold, sound gating and similar). The block grants the counter to one requester at a time in round-robin order. It loads that requester's interval length, counts qualifying ticks, and pulses a per-requester `done` when the interval expires. It sits between the scene/control logic and the shared prescaler tick, replacing per-client free-running counters.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4 for this revision.
- `W`, 6: counter and interval width.

- `clock`  in  1  system clock; all state on rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `tick`  in  1  count-enable pulse from the prescaler; one cycle wide.
- `req`  in  4  level request per requester; held until `done` or abort.
- `len`  in  24  interval per requester; `len[6*i+5:6*i]` for requester i, in ticks.
- `grant`  out  4  one-hot owner of the counter; 0 when idle.
- `done`  out  4  one-cycle pulse to the owner when its interval completes.
- `busy`  out  1  counter owned (state ≠ IDLE).
- `count`  out  6  current tick count of the active interval.

## Operation
- The state machine has four states: IDLE, LOAD, RUN, FIN. The state is binary-encoded. All outputs are decoded from registers, with no combinational path from inputs to outputs.
- **IDLE**: `grant`=0 and `count`=0. If `req`≠0, select the first set bit at or after round-robin pointer `ptr`, scanning upward and wrapping 3→0. Register it into `grant` and go to LOAD.
- **LOAD**: capture the owner's `len` slice into `len_q` and clear `count`. If `len_q` would be 0, go straight to FIN (a zero-tick interval). Otherwise go to RUN.
- **RUN**: when `tick`=1, `count` becomes `count`+1. If `count`+1 == `len_q` on that tick, go to FIN. When `tick`=0, `count` holds.
- **FIN**: `done[owner]`=1 for exactly this cycle and `grant` is still held. Next state is IDLE, and `ptr` becomes owner+1 mod 4.
- **Abort**: in LOAD or RUN, if `req[owner]`=0, the next state is IDLE. `grant` and `count` clear, no `done` pulse is issued, and `ptr` advances past the owner.
- `len` changes after LOAD are ignored; only `len_q` is used.
- `count` never wraps. The maximum interval is 63 ticks, and `count` reaches at most `len_q`−1 before FIN.
- A request still asserted after its own `done` is a new request. It competes at lowest priority because `ptr` has moved past it.
- `tick` arriving in IDLE, LOAD or FIN is ignored.

## Timing
- **Reset values**: state IDLE, `grant`=0, `done`=0, `busy`=0, `count`=0, `ptr`=0, `len_q`=0.
- **Request to grant**: with `req` seen in IDLE at cycle k, `grant` and `busy` are high from cycle k+1 (LOAD).
- **Zero interval**: with `len`=0, `done` is at k+2 and IDLE at k+3.
- **Nonzero interval**: with `len`=N>0, FIN (the `done` cycle) is the cycle after the clock edge that samples the Nth `tick` in RUN. The earliest ticks that count are those sampled from cycle k+2 onward.
- **Back-to-back grants**: the minimum gap between grants is one IDLE cycle after FIN. Back-to-back service of different requesters therefore costs 3 cycles of overhead.
- **`clr` mid-operation**: the block returns immediately to reset values. A pending `done` is lost, and requesters must re-request.
- **Simultaneous abort and final tick in RUN**: abort wins, and no `done` is issued.

## Test plan
- Reset with `req`=0 → all outputs 0. Assert `req`=4'b0010 with `len[11:6]`=5 and `tick` high every cycle → `grant`=4'b0010 from the next cycle, `count` steps 0..4, then `done`=4'b0010 for one cycle, then `grant`=0.
- `req`=4'b1111, all `len`=2, each requester dropping its `req` the cycle after its `done` → grants in order 0001, 0010, 0100, 1000. `done` pulses appear in the same order, and there is never more than one `grant` bit set.
- `len`=0 for requester 3 with `req`=4'b1000 → `done[3]` two cycles after the request is seen, and `count` stays 0.
- `len`=63 with `tick` every 4th cycle → `done` follows the 63rd tick and `count` peaks at 62 (no wrap). Repeat with `len`=1 → `done` after the first tick.
- Owner drops `req` mid-RUN at `count`=3 → IDLE next cycle with no `done`. A pending `req[2]` is granted next even if it sits below the old owner's index, per `ptr`.
- Pulse `clr` asynchronously mid-RUN at `count`=10 → outputs zero immediately. After `clr` falls with `req` still held, a fresh grant arrives with `count` restarting at 0.

Source files
------------

// File: rtl/delay_slot_arbiter.sv
// rtl/delay_slot_arbiter.sv - round-robin arbiter sharing one tick counter among timed-interval requesters
module delay_slot_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 6
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              tick,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      count
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [W-1:0]    r_count;
  logic [W-1:0]    r_len_q;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;

  logic            w_any_req;
  logic [PW-1:0]   w_sel;
  logic [PW-1:0]   w_idx;
  logic [NREQ-1:0] w_sel_onehot;
  logic [W-1:0]    w_len_own;
  logic            w_own_req;
  logic [W-1:0]    w_count_inc;
  logic            w_last_tick;

  assign w_any_req    = |req;
  assign w_sel_onehot = NREQ'(1) << w_sel;
  assign w_own_req    = req[r_owner];
  assign w_count_inc  = r_count + W'(1);
  assign w_last_tick  = (w_count_inc == r_len_q);

  // Round-robin pick: first requester at or above r_ptr, wrapping; smallest offset wins
  always_comb begin
    w_sel = r_ptr;
    w_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = r_ptr + PW'(i);
      if (req[w_idx]) begin
        w_sel = w_idx;
      end
    end
  end

  // Interval length of the current owner, selected with constant slices
  always_comb begin
    w_len_own = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == PW'(i)) begin
        w_len_own = len[i*W +: W];
      end
    end
  end

  // Arbiter state machine; done is a one-cycle pulse set on entry to FIN
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_count <= '0;
      r_len_q <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant <= w_sel_onehot;
            r_owner <= w_sel;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!w_own_req) begin
            // owner withdrew before the interval started
            r_state <= S_IDLE;
            r_grant <= '0;
            r_count <= '0;
            r_ptr   <= r_owner + PW'(1);
          end else begin
            r_len_q <= w_len_own;
            r_count <= '0;
            if (w_len_own == '0) begin
              r_state <= S_FIN;
              r_done  <= r_grant;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!w_own_req) begin
            // abort takes priority over a coincident final tick
            r_state <= S_IDLE;
            r_grant <= '0;
            r_count <= '0;
            r_ptr   <= r_owner + PW'(1);
          end else if (tick) begin
            if (w_last_tick) begin
              // count holds at len_q-1 so it never reaches or wraps past len_q
              r_state <= S_FIN;
              r_done  <= r_grant;
            end else begin
              r_count <= w_count_inc;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_count <= '0;
          r_ptr   <= r_owner + PW'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = (r_state != S_IDLE);
  assign count = r_count;

endmodule

// File: tb/tb_delay_slot_arbiter.sv
// tb/tb_delay_slot_arbiter.sv - self-checking bench for delay_slot_arbiter
module tb_delay_slot_arbiter;

  logic        clock = 1'b0;
  logic        clr;
  logic        tick;
  logic [3:0]  req;
  logic [23:0] len;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [5:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one service record (owner, captured length, ticks counted)
  int m_owner;
  bit m_loaded;
  bit m_fin;
  int m_len;
  int m_ticks;
  int m_ptr;

  logic [3:0] done_log[$];
  logic [3:0] exp_order[4];
  int n;
  int max_count;

  always #5 clock = ~clock;

  delay_slot_arbiter #(.NREQ(4), .W(6)) dut (
    .clock (clock),
    .clr   (clr),
    .tick  (tick),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner  = -1;
    m_loaded = 0;
    m_fin    = 0;
    m_len    = 0;
    m_ticks  = 0;
    m_ptr    = 0;
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++) begin
      if (r[(p + off) % 4]) return (p + off) % 4;
    end
    return -1;
  endfunction

  // Advance the service record by one sampled clock edge
  function automatic void model_step();
    if (m_owner < 0) begin
      if (req != 4'd0) begin
        m_owner  = rr_pick(req, m_ptr);
        m_loaded = 0;
        m_fin    = 0;
        m_ticks  = 0;
      end
    end else if (m_fin) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_fin   = 0;
    end else if (!req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
    end else if (!m_loaded) begin
      m_len    = int'((len >> (6 * m_owner)) & 24'd63);
      m_loaded = 1;
      m_fin    = (m_len == 0);
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == m_len) m_fin = 1;
    end
  endfunction

  task automatic compare_all();
    int exp_count;
    if (m_owner < 0) exp_count = 0;
    else if (m_fin) exp_count = (m_len == 0) ? 0 : m_len - 1;
    else exp_count = m_ticks;
    check("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    check("done", done, (m_owner >= 0 && m_fin) ? (1 << m_owner) : 0);
    check("busy", busy, (m_owner >= 0) ? 1 : 0);
    check("count", count, exp_count);
  endtask

  task automatic cycle();
    @(posedge clock);
    if (clr) model_reset();
    else model_step();
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    clr  = 1'b1;
    req  = 4'd0;
    len  = 24'd0;
    tick = 1'b0;
    model_reset();
    @(negedge clock);
    compare_all();
    clr = 1'b0;
    cycle();

    // All four requesting, len 2 each, each drops req after its done
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    len  = {6'd2, 6'd2, 6'd2, 6'd2};
    req  = 4'b1111;
    tick = 1'b1;
    n = 0;
    while (done_log.size() < 4 && n < 60) begin
      cycle();
      check("rr_onehot", $onehot0(grant), 1);
      if (done != 4'd0) begin
        done_log.push_back(done);
        req = req & ~done;
      end
      n++;
    end
    check("rr_done_count", done_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < done_log.size()) check("rr_done_order", done_log[i], exp_order[i]);
    end
    req = 4'd0;
    cycle();

    // Requester 1, len 5, tick every cycle
    len  = 24'd5 << 6;
    req  = 4'b0010;
    tick = 1'b1;
    cycle();
    check("basic_grant_next", grant, 4'b0010);
    n = 0;
    while (done == 4'd0 && n < 20) begin
      cycle();
      n++;
    end
    check("basic_done", done, 4'b0010);
    check("basic_latency", n, 6);
    req = 4'd0;
    cycle();
    check("basic_release", grant, 4'b0000);

    // Zero-length interval for requester 3
    len  = 24'd0;
    req  = 4'b1000;
    n = 0;
    while (done == 4'd0 && n < 10) begin
      cycle();
      n++;
      check("zero_count", count, 0);
    end
    check("zero_done", done, 4'b1000);
    check("zero_latency", n, 2);
    req = 4'd0;
    cycle();

    // len 63, tick every 4th cycle: count peaks at 62
    len  = 24'd63;
    req  = 4'b0001;
    n = 0;
    max_count = 0;
    while (done == 4'd0 && n < 400) begin
      tick = (n % 4 == 3);
      cycle();
      if (int'(count) > max_count) max_count = int'(count);
      n++;
    end
    check("long_done", done, 4'b0001);
    check("long_peak", max_count, 62);
    req  = 4'd0;
    tick = 1'b0;
    cycle();

    // len 1: done after the first counted tick
    len = 24'd1;
    req = 4'b0001;
    n = 0;
    max_count = 0;
    while (done == 4'd0 && n < 40) begin
      tick = (n % 4 == 3);
      cycle();
      if (int'(count) > max_count) max_count = int'(count);
      n++;
    end
    check("one_done", done, 4'b0001);
    check("one_peak", max_count, 0);
    req  = 4'd0;
    tick = 1'b0;
    cycle();

    // Abort by requester 3 at count 3; pending requester 2 is next
    len  = 24'd20 << 18;
    req  = 4'b1000;
    tick = 1'b1;
    cycle();
    req = 4'b1100;
    n = 0;
    while (count != 6'd3 && n < 20) begin
      cycle();
      n++;
    end
    check("abort_reached3", count, 3);
    req = 4'b0100;
    cycle();
    check("abort_grant", grant, 4'b0000);
    check("abort_nodone", done, 4'b0000);
    cycle();
    check("abort_next_grant", grant, 4'b0100);
    req = 4'd0;
    cycle();
    cycle();

    // Asynchronous clr mid-run at count 10
    len  = 24'd20;
    req  = 4'b0001;
    tick = 1'b1;
    n = 0;
    while (count != 6'd10 && n < 40) begin
      cycle();
      n++;
    end
    check("clr_reached10", count, 10);
    #2 clr = 1'b1;
    #1;
    model_reset();
    check("clr_grant", grant, 0);
    check("clr_done", done, 0);
    check("clr_busy", busy, 0);
    check("clr_count", count, 0);
    @(negedge clock);
    clr = 1'b0;
    cycle();
    check("clr_regrant", grant, 4'b0001);
    check("clr_restart", count, 0);
    n = 0;
    while (done == 4'd0 && n < 40) begin
      cycle();
      n++;
    end
    check("clr_done_after", done, 4'b0001);
    req = 4'd0;
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 4; i++) begin
          len[i*6 +: 6] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                      : 6'($urandom_range(0, 6));
        end
      end
      tick = ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 199) == 0);
      cycle();
    end
    clr = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
